// File: rtl/s_core_pkg.sv
// Shared definitions for the s_core boot path.
//   ld_state_e : loader FSM states
//   RESET_PC   : byte address where s_core starts executing after boot
//   word_addr  : byte address of a word slot given a base and a word index
package s_core_pkg;

  typedef enum logic [2:0] {
    LD_HDR,
    LD_DATA,
    LD_CSUM,
    LD_RUN,
    LD_ERR
  } ld_state_e;

  localparam logic [31:0] RESET_PC = 32'h0000_0004;

  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/s_core_imem_loader_if.sv
// Loader bus bundle: incoming byte stream plus outgoing instruction-memory
// write port.
//   i_ld_valid / i_ld_byte / o_ld_ready : byte stream handshake
//   o_imem_we / o_imem_addr / o_imem_wdata : one-cycle word write strobe
// master = stream source / memory side, slave = loader.
interface s_core_imem_loader_if;

  logic        i_ld_valid;
  logic [7:0]  i_ld_byte;
  logic        o_ld_ready;
  logic        o_imem_we;
  logic [31:0] o_imem_addr;
  logic [31:0] o_imem_wdata;

  modport master (
    output i_ld_valid,
    output i_ld_byte,
    input  o_ld_ready,
    input  o_imem_we,
    input  o_imem_addr,
    input  o_imem_wdata
  );

  modport slave (
    input  i_ld_valid,
    input  i_ld_byte,
    output o_ld_ready,
    output o_imem_we,
    output o_imem_addr,
    output o_imem_wdata
  );

endinterface

// File: rtl/ld_byte_packer.sv
// Packs accepted stream bytes little-endian into 32-bit words.
//   clk, rst_n  : clock, synchronous active-low reset
//   clr         : synchronous clear of a partial word
//   byte_valid  : a byte is transferred this cycle
//   byte_in     : the transferred byte
//   word_valid  : combinational, high in the cycle the 4th byte transfers
//   word        : assembled word, valid together with word_valid
module ld_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] shreg;

  // Bytes enter at the top so that after three bytes shreg = {b2, b1, b0};
  // the fourth byte is combined directly to avoid a cycle of latency.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (byte_valid) begin
      cnt   <= cnt + 2'd1;
      shreg <= {byte_in, shreg[23:8]};
    end
  end

  assign word_valid = byte_valid && (cnt == 2'd3);
  assign word       = {byte_in, shreg};

endmodule

// File: rtl/s_core_imem_loader.sv
// Boot loader for s_core: receives a framed byte stream (count, payload,
// checksum), writes the payload words into instruction memory from
// BASE_ADDR upward and releases the core on a matching checksum.
//   clk, rst_n    : clock, synchronous active-low reset
//   bus (slave)   : byte stream in, instruction-memory write port out
//   i_reload      : one-cycle reload request, honoured only in RUN
//   o_core_rst_n  : s_core reset (0 = held), 1 only in RUN
//   o_start_pc    : start PC, constant BASE_ADDR
//   o_done        : high in RUN
//   o_err         : high in ERR (only rst_n leaves ERR)
module s_core_imem_loader
  import s_core_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR  = RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  s_core_imem_loader_if.slave  bus,
  input  logic                 i_reload,
  output logic                 o_core_rst_n,
  output logic [31:0]          o_start_pc,
  output logic                 o_done,
  output logic                 o_err
);

  localparam int unsigned IDX_W = $clog2(IMEM_DEPTH + 1);

  ld_state_e        state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [IDX_W-1:0] n_words;
  logic [31:0]      sum;
  logic             ld_ready;
  logic             imem_we;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_wdata;
  logic             core_rst_n;
  logic             done;
  logic             err;

  logic             byte_fire;
  logic             reload_fire;
  logic             word_valid;
  logic [31:0]      word;

  assign byte_fire   = bus.i_ld_valid && ld_ready;
  assign reload_fire = (state == LD_RUN) && i_reload;
  assign idx_next    = idx + 1'b1;

  ld_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (reload_fire),
    .byte_valid (byte_fire),
    .byte_in    (bus.i_ld_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  // ld_ready, core_rst_n, done and err are registered alongside the state so
  // each is a direct flop output that changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LD_HDR;
      idx        <= '0;
      n_words    <= '0;
      sum        <= '0;
      ld_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        LD_HDR: begin
          if (word_valid) begin
            if (word > 32'(IMEM_DEPTH)) begin
              state    <= LD_ERR;
              ld_ready <= 1'b0;
              err      <= 1'b1;
            end else if (word == '0) begin
              sum   <= '0;
              state <= LD_CSUM;
            end else begin
              n_words <= word[IDX_W-1:0];
              idx     <= '0;
              sum     <= '0;
              state   <= LD_DATA;
            end
          end
        end
        LD_DATA: begin
          if (word_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_addr(BASE_ADDR, 32'(idx));
            imem_wdata <= word;
            sum        <= sum + word;
            idx        <= idx_next;
            if (idx_next == n_words) begin
              state <= LD_CSUM;
            end
          end
        end
        LD_CSUM: begin
          if (word_valid) begin
            ld_ready <= 1'b0;
            if (word == sum) begin
              state      <= LD_RUN;
              core_rst_n <= 1'b1;
              done       <= 1'b1;
            end else begin
              state <= LD_ERR;
              err   <= 1'b1;
            end
          end
        end
        LD_RUN: begin
          if (i_reload) begin
            state      <= LD_HDR;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            ld_ready   <= 1'b1;
            idx        <= '0;
            sum        <= '0;
          end
        end
        LD_ERR: begin
        end
        default: begin
          state      <= LD_ERR;
          ld_ready   <= 1'b0;
          core_rst_n <= 1'b0;
          done       <= 1'b0;
          err        <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_ld_ready   = ld_ready;
  assign bus.o_imem_we    = imem_we;
  assign bus.o_imem_addr  = imem_addr;
  assign bus.o_imem_wdata = imem_wdata;
  assign o_core_rst_n     = core_rst_n;
  assign o_start_pc       = BASE_ADDR;
  assign o_done           = done;
  assign o_err            = err;

endmodule
